// File: rtl/external_bus_arbiter_pkg.sv
// Shared definitions for the two-master external bus arbiter: bus widths,
// acknowledge timeout default, FSM encoding and the bus command record.
package external_bus_arbiter_pkg;

    localparam int ADDR_W          = 20;
    localparam int DATA_W          = 16;
    localparam int BE_W            = 2;
    localparam int TIMEOUT_DEFAULT = 16;

    // FSM encoding kept as plain constants so legacy tools can consume it.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One external bus command, as latched from the granted master.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byte_enable;
        logic              rw;
        logic [DATA_W-1:0] write_data;
    } bus_cmd_t;

    // Idle bus command: everything low except rw, which rests at read.
    localparam bus_cmd_t CMD_RESET = '{
        address:     {ADDR_W{1'b0}},
        byte_enable: {BE_W{1'b0}},
        rw:          1'b1,
        write_data:  {DATA_W{1'b0}}
    };

endpackage

// File: rtl/external_bus_arbiter_if.sv
// Bundle of master-side request/response signals and the external bus.
// slave: the arbiter's view; master: the view of whatever drives requests
// and models the external slave.
interface external_bus_arbiter_if;
    import external_bus_arbiter_pkg::*;

    logic              m0_req;
    logic [ADDR_W-1:0] m0_address;
    logic [BE_W-1:0]   m0_byte_enable;
    logic              m0_rw;
    logic [DATA_W-1:0] m0_write_data;
    logic              m0_ack;
    logic              m0_err;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_address;
    logic [BE_W-1:0]   m1_byte_enable;
    logic              m1_rw;
    logic [DATA_W-1:0] m1_write_data;
    logic              m1_ack;
    logic              m1_err;

    logic [DATA_W-1:0] m_read_data;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byte_enable;
    logic              rw;
    logic [DATA_W-1:0] write_data;
    logic              bus_enable;
    logic              acknowledge;
    logic [DATA_W-1:0] read_data;

    modport slave (
        input  m0_req, m0_address, m0_byte_enable, m0_rw, m0_write_data,
        input  m1_req, m1_address, m1_byte_enable, m1_rw, m1_write_data,
        input  acknowledge, read_data,
        output m0_ack, m0_err, m1_ack, m1_err, m_read_data,
        output address, byte_enable, rw, write_data, bus_enable
    );

    modport master (
        output m0_req, m0_address, m0_byte_enable, m0_rw, m0_write_data,
        output m1_req, m1_address, m1_byte_enable, m1_rw, m1_write_data,
        output acknowledge, read_data,
        input  m0_ack, m0_err, m1_ack, m1_err, m_read_data,
        input  address, byte_enable, rw, write_data, bus_enable
    );

endinterface

// File: rtl/external_bus_arbiter_rr_arbiter2.sv
// Two-way round-robin grant selection. With both requests present the
// master that was not granted last wins; a lone request always wins.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant
);

    // Pick the grant index from the current requests and the last winner.
    always_comb begin
        o_grant = 1'b0;
        if (i_req == 2'b11) begin
            o_grant = ~i_last_grant;
        end else if (i_req[1]) begin
            o_grant = 1'b1;
        end else begin
            o_grant = 1'b0;
        end
    end

endmodule

// File: rtl/external_bus_arbiter.sv
// Two-master external bus arbiter. IDLE grants and latches a command,
// BUSY drives the bus until the slave acknowledges or the timeout expires,
// DONE reports ack or err to the granted master for one cycle.
module external_bus_arbiter
    import external_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic                   clk_clk,
    input logic                   reset_reset_n,
    external_bus_arbiter_if.slave bus
);

    localparam int               CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);

    logic [1:0]        r_state;
    logic              r_grant;
    logic              r_last_grant;
    logic [CNT_W-1:0]  r_count;
    logic              r_bus_enable;
    logic [1:0]        r_ack;
    logic [1:0]        r_err;
    bus_cmd_t          r_cmd;
    logic [DATA_W-1:0] r_read_data;

    logic [1:0]        w_req;
    logic              w_any_req;
    logic              w_grant;
    logic              w_start;
    logic              w_capture;
    logic [1:0]        w_grant_onehot;
    bus_cmd_t          w_cmd;

    assign w_req          = {bus.m1_req, bus.m0_req};
    assign w_any_req      = |w_req;
    assign w_start        = (r_state == ST_IDLE) && w_any_req;
    assign w_capture      = (r_state == ST_BUSY) && bus.acknowledge;
    assign w_grant_onehot = r_grant ? 2'b10 : 2'b01;

    rr_arbiter2 u_rr_arbiter2 (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Select the command fields of the master the arbiter would grant.
    always_comb begin
        w_cmd = CMD_RESET;
        if (w_grant) begin
            w_cmd = '{bus.m1_address, bus.m1_byte_enable, bus.m1_rw, bus.m1_write_data};
        end else begin
            w_cmd = '{bus.m0_address, bus.m0_byte_enable, bus.m0_rw, bus.m0_write_data};
        end
    end

    // Transfer sequencing: grant, bus strobe, timeout count and completion pulses.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_count      <= CNT_ZERO;
            r_bus_enable <= 1'b0;
            r_ack        <= 2'b00;
            r_err        <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 2'b00;
                    r_err <= 2'b00;
                    if (w_any_req) begin
                        r_grant      <= w_grant;
                        r_last_grant <= w_grant;
                        r_count      <= CNT_ZERO;
                        r_bus_enable <= 1'b1;
                        r_state      <= ST_BUSY;
                    end else begin
                        r_bus_enable <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Acknowledge is tested first so it wins on the timeout cycle.
                    if (bus.acknowledge) begin
                        r_bus_enable <= 1'b0;
                        r_ack        <= w_grant_onehot;
                        r_state      <= ST_DONE;
                    end else if (r_count == CNT_LAST) begin
                        r_count      <= CNT_TIMEOUT;
                        r_bus_enable <= 1'b0;
                        r_err        <= w_grant_onehot;
                        r_state      <= ST_DONE;
                    end else begin
                        r_count      <= r_count + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    r_ack        <= 2'b00;
                    r_err        <= 2'b00;
                    r_bus_enable <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_ack        <= 2'b00;
                    r_err        <= 2'b00;
                    r_bus_enable <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus command registers: loaded only at grant so they hold through BUSY.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cmd <= CMD_RESET;
        end else if (w_start) begin
            r_cmd <= w_cmd;
        end else begin
            r_cmd <= r_cmd;
        end
    end

    // Read data capture on a successful read; writes and timeouts keep the old value.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_read_data <= {DATA_W{1'b0}};
        end else if (w_capture && r_cmd.rw) begin
            r_read_data <= bus.read_data;
        end else begin
            r_read_data <= r_read_data;
        end
    end

    assign bus.address     = r_cmd.address;
    assign bus.byte_enable = r_cmd.byte_enable;
    assign bus.rw          = r_cmd.rw;
    assign bus.write_data  = r_cmd.write_data;
    assign bus.bus_enable  = r_bus_enable;
    assign bus.m_read_data = r_read_data;
    assign bus.m0_ack      = r_ack[0];
    assign bus.m1_ack      = r_ack[1];
    assign bus.m0_err      = r_err[0];
    assign bus.m1_err      = r_err[1];

endmodule

// File: tb/tb_external_bus_arbiter.sv
// Scoreboard bench for external_bus_arbiter: directed transfers push the
// expected bus command and master response; a monitor pops and compares.
module tb_external_bus_arbiter;

    logic clk_clk       = 1'b0;
    logic reset_reset_n = 1'b0;

    always #5 clk_clk = ~clk_clk;

    external_bus_arbiter_if bus_if ();

    external_bus_arbiter #(.TIMEOUT(16)) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .bus           (bus_if)
    );

    typedef struct {
        logic [19:0] a;
        logic [1:0]  be;
        logic        rw;
        logic [15:0] wd;
        int          len;
    } exp_cmd_t;

    typedef struct {
        int          m;
        bit          err;
        logic [15:0] rd;
    } exp_rsp_t;

    exp_cmd_t cmd_q[$];
    exp_rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;

    int slave_delay = 1;   // BUSY cycle in which the slave acks; 0 = never
    bit stray_ack   = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void expect_xfer(input int m, input logic [19:0] a, input logic [1:0] be,
                                        input logic rw, input logic [15:0] wd, input int len,
                                        input bit err, input logic [15:0] rd);
        exp_cmd_t c;
        exp_rsp_t r;
        c.a = a; c.be = be; c.rw = rw; c.wd = wd; c.len = len;
        r.m = m; r.err = err; r.rd = rd;
        cmd_q.push_back(c);
        rsp_q.push_back(r);
    endfunction

    // Slave model: acks in the chosen BUSY cycle, returning address[15:0].
    int busy_cnt = 0;
    initial begin
        forever begin
            @(negedge clk_clk);
            if (bus_if.bus_enable) begin
                busy_cnt++;
                if (slave_delay != 0 && busy_cnt == slave_delay) begin
                    bus_if.acknowledge = 1'b1;
                    bus_if.read_data   = bus_if.address[15:0];
                end else begin
                    bus_if.acknowledge = 1'b0;
                    bus_if.read_data   = 16'hDEAD;
                end
            end else begin
                busy_cnt           = 0;
                bus_if.acknowledge = stray_ack;
                bus_if.read_data   = 16'hDEAD;
            end
        end
    end

    // Monitor: compares bus commands, BUSY length and master responses.
    bit       prev_be = 1'b0;
    int       blen    = 0;
    bit       stable  = 1'b1;
    exp_cmd_t cur;
    exp_rsp_t rsp;
    logic [3:0] outs;
    initial begin
        cur.len = 0;
        forever begin
            @(negedge clk_clk);
            if (!reset_reset_n) begin
                prev_be = 1'b0;
                blen    = 0;
            end else begin
                outs = {bus_if.m1_err, bus_if.m1_ack, bus_if.m0_err, bus_if.m0_ack};
                chk("rsp_exclusive", ($countones(outs) > 1) ? 32'd1 : 32'd0, 32'd0);
                if (bus_if.bus_enable && !prev_be) begin
                    if (cmd_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_cmd: got address 0x%0h expected none", bus_if.address);
                        cur.len = -1;
                    end else begin
                        cur = cmd_q.pop_front();
                        chk("cmd_address", 32'(bus_if.address), 32'(cur.a));
                        chk("cmd_byte_enable", 32'(bus_if.byte_enable), 32'(cur.be));
                        chk("cmd_rw", 32'(bus_if.rw), 32'(cur.rw));
                        chk("cmd_write_data", 32'(bus_if.write_data), 32'(cur.wd));
                    end
                    blen   = 1;
                    stable = 1'b1;
                end else if (bus_if.bus_enable) begin
                    blen++;
                    if (bus_if.address !== cur.a || bus_if.byte_enable !== cur.be ||
                        bus_if.rw !== cur.rw || bus_if.write_data !== cur.wd) stable = 1'b0;
                end
                if (!bus_if.bus_enable && prev_be) begin
                    chk("busy_len", 32'(blen), 32'(cur.len));
                    chk("cmd_stable", 32'(stable), 32'd1);
                end
                if (|outs) begin
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp: got outs 0x%0h expected none", outs);
                    end else begin
                        rsp = rsp_q.pop_front();
                        chk("rsp_master", (bus_if.m1_ack | bus_if.m1_err) ? 32'd1 : 32'd0, 32'(rsp.m));
                        chk("rsp_is_err", 32'(bus_if.m0_err | bus_if.m1_err), 32'(rsp.err));
                        chk("rsp_rdata", 32'(bus_if.m_read_data), 32'(rsp.rd));
                        chk("rsp_after_busy", 32'(prev_be), 32'd1);
                    end
                end
                prev_be = bus_if.bus_enable;
            end
        end
    end

    // Master driver: holds req until own ack/err (or reset), bounded wait.
    task automatic xfer(input int m, input logic [19:0] a, input logic [1:0] be,
                        input logic rw, input logic [15:0] wd, input bit drop_early);
        bit done    = 1'b0;
        bit aborted = 1'b0;
        if (m == 0) begin
            bus_if.m0_address = a; bus_if.m0_byte_enable = be;
            bus_if.m0_rw = rw; bus_if.m0_write_data = wd; bus_if.m0_req = 1'b1;
        end else begin
            bus_if.m1_address = a; bus_if.m1_byte_enable = be;
            bus_if.m1_rw = rw; bus_if.m1_write_data = wd; bus_if.m1_req = 1'b1;
        end
        for (int i = 1; i <= 100 && !done; i++) begin
            @(negedge clk_clk);
            if (!reset_reset_n) aborted = 1'b1;
            if (aborted || ((m == 0) ? (bus_if.m0_ack | bus_if.m0_err)
                                     : (bus_if.m1_ack | bus_if.m1_err))) done = 1'b1;
            if (drop_early && i == 2) begin
                if (m == 0) bus_if.m0_req = 1'b0;
                else        bus_if.m1_req = 1'b0;
            end
        end
        if (m == 0) bus_if.m0_req = 1'b0;
        else        bus_if.m1_req = 1'b0;
        if (!aborted) chk($sformatf("m%0d_complete", m), 32'(done), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bus_enable"}, 32'(bus_if.bus_enable), 32'd0);
        chk({tag, "_ack_err"}, 32'({bus_if.m1_err, bus_if.m1_ack, bus_if.m0_err, bus_if.m0_ack}), 32'd0);
        chk({tag, "_address"}, 32'(bus_if.address), 32'd0);
        chk({tag, "_byte_enable"}, 32'(bus_if.byte_enable), 32'd0);
        chk({tag, "_rw"}, 32'(bus_if.rw), 32'd1);
        chk({tag, "_write_data"}, 32'(bus_if.write_data), 32'd0);
        chk({tag, "_m_read_data"}, 32'(bus_if.m_read_data), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.m0_req = 1'b0; bus_if.m0_address = 20'h0; bus_if.m0_byte_enable = 2'b00;
        bus_if.m0_rw = 1'b0; bus_if.m0_write_data = 16'h0;
        bus_if.m1_req = 1'b0; bus_if.m1_address = 20'h0; bus_if.m1_byte_enable = 2'b00;
        bus_if.m1_rw = 1'b0; bus_if.m1_write_data = 16'h0;
        bus_if.acknowledge = 1'b0; bus_if.read_data = 16'h0;

        repeat (3) @(negedge clk_clk);
        check_reset_vals("por");
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        // Both masters read continuously: m0 first after reset, then alternate.
        slave_delay = 1;
        expect_xfer(0, 20'h11111, 2'b11, 1'b1, 16'h0, 1, 1'b0, 16'h1111);
        expect_xfer(1, 20'h22222, 2'b11, 1'b1, 16'h0, 1, 1'b0, 16'h2222);
        expect_xfer(0, 20'h13333, 2'b11, 1'b1, 16'h0, 1, 1'b0, 16'h3333);
        expect_xfer(1, 20'h24444, 2'b11, 1'b1, 16'h0, 1, 1'b0, 16'h4444);
        fork
            begin
                xfer(0, 20'h11111, 2'b11, 1'b1, 16'h0, 1'b0);
                xfer(0, 20'h13333, 2'b11, 1'b1, 16'h0, 1'b0);
            end
            begin
                xfer(1, 20'h22222, 2'b11, 1'b1, 16'h0, 1'b0);
                xfer(1, 20'h24444, 2'b11, 1'b1, 16'h0, 1'b0);
            end
        join

        // m0 write, ack in second BUSY cycle; read data must not change.
        slave_delay = 2;
        expect_xfer(0, 20'h00003, 2'b11, 1'b0, 16'hBEEF, 2, 1'b0, 16'h4444);
        xfer(0, 20'h00003, 2'b11, 1'b0, 16'hBEEF, 1'b0);

        // m1 read with no ack: 16 BUSY cycles then m1_err.
        slave_delay = 0;
        expect_xfer(1, 20'h25555, 2'b11, 1'b1, 16'h0, 16, 1'b1, 16'h4444);
        xfer(1, 20'h25555, 2'b11, 1'b1, 16'h0, 1'b0);

        // Ack on the very cycle the timeout would fire: success.
        slave_delay = 16;
        expect_xfer(0, 20'h16666, 2'b11, 1'b1, 16'h0, 16, 1'b0, 16'h6666);
        xfer(0, 20'h16666, 2'b11, 1'b1, 16'h0, 1'b0);

        // Stray acknowledge while idle must be ignored.
        stray_ack = 1'b1;
        repeat (4) begin
            @(negedge clk_clk);
            chk("stray_idle", 32'({bus_if.bus_enable, bus_if.m1_err, bus_if.m1_ack,
                                   bus_if.m0_err, bus_if.m0_ack}), 32'd0);
        end
        stray_ack = 1'b0;
        @(negedge clk_clk);

        // Reset mid-BUSY: outputs drop asynchronously.
        slave_delay = 0;
        expect_xfer(1, 20'h2AAAA, 2'b01, 1'b1, 16'h0, 16, 1'b1, 16'h6666);
        fork
            xfer(1, 20'h2AAAA, 2'b01, 1'b1, 16'h0, 1'b0);
            begin
                repeat (4) @(posedge clk_clk);
                #1;
                chk("busy_before_reset", 32'(bus_if.bus_enable), 32'd1);
                #1;
                reset_reset_n = 1'b0;
                #1;
                check_reset_vals("mid_busy");
                cmd_q.delete();
                rsp_q.delete();
                @(negedge clk_clk);
                @(negedge clk_clk);
                reset_reset_n = 1'b1;
            end
        join

        // First dual request after reset goes to m0.
        slave_delay = 1;
        expect_xfer(0, 20'h17777, 2'b11, 1'b1, 16'h0, 1, 1'b0, 16'h7777);
        expect_xfer(1, 20'h28888, 2'b11, 1'b1, 16'h0, 1, 1'b0, 16'h8888);
        fork
            xfer(0, 20'h17777, 2'b11, 1'b1, 16'h0, 1'b0);
            xfer(1, 20'h28888, 2'b11, 1'b1, 16'h0, 1'b0);
        join

        // m1 drops req during BUSY; completion is still reported.
        slave_delay = 3;
        expect_xfer(1, 20'h29999, 2'b10, 1'b0, 16'h1234, 3, 1'b0, 16'h8888);
        xfer(1, 20'h29999, 2'b10, 1'b0, 16'h1234, 1'b1);

        repeat (3) @(negedge clk_clk);
        chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
